// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: IF stage with IF/ID pipeline register.
// Owns the PC and issues requests to instruction memory with a req/ready handshake.
// It buffers a returned word while the stage is stalled.
// A branch redirect from EXE loads a new PC and flushes IF/ID.
// Optional feature macro: FETCH_PERF_COUNT_EN adds stall and flush performance counters.
module instruction_fetch_stage #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned RESET_PC    = 0,
    parameter int unsigned PC_STEP     = 4
) (
    input  logic                   Clock,
    input  logic                   Reset_N,
    input  logic                   Hazard_Detected,
    input  logic                   Branch_Taken,
    input  logic [ADDR_WIDTH-1:0]  Branch_Target,
    output logic                   Instr_Mem_Req,
    output logic [ADDR_WIDTH-1:0]  Instr_Mem_Addr,
    input  logic                   Instr_Mem_Ready,
    input  logic [INSTR_WIDTH-1:0] Instr_Mem_Data,
    output logic [ADDR_WIDTH-1:0]  PC_IF_ID,
    output logic [INSTR_WIDTH-1:0] Instruction_IF_ID,
    output logic                   Valid_IF_ID,
`ifdef FETCH_PERF_COUNT_EN
    output logic [15:0]            Stall_Cycle_Count,
    output logic [15:0]            Flush_Count,
`endif
    output logic                   Fetch_Stall
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [1:0]             state_r,       state_s;
    logic [ADDR_WIDTH-1:0]  pc_r,          pc_s;
    logic [ADDR_WIDTH-1:0]  pc_if_id_r,    pc_if_id_s;
    logic [INSTR_WIDTH-1:0] instr_if_id_r, instr_if_id_s;
    logic                   valid_if_id_r, valid_if_id_s;
    logic [ADDR_WIDTH-1:0]  pend_pc_r,     pend_pc_s;
    logic [INSTR_WIDTH-1:0] pend_instr_r,  pend_instr_s;
    logic                   pend_valid_r,  pend_valid_s;
    logic [ADDR_WIDTH-1:0]  pc_inc_s;

    // Memory-facing outputs decode only registered state, so there is no input-to-output path.
    assign Instr_Mem_Req     = (state_r == ST_REQ) || (state_r == ST_WAIT);
    assign Instr_Mem_Addr    = pc_r;
    assign Fetch_Stall       = (state_r == ST_WAIT) || (state_r == ST_HOLD);
    assign PC_IF_ID          = pc_if_id_r;
    assign Instruction_IF_ID = instr_if_id_r;
    assign Valid_IF_ID       = valid_if_id_r;

    // Next-state logic; a branch redirect overrides stalls and returning data.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        pc_if_id_s    = pc_if_id_r;
        instr_if_id_s = instr_if_id_r;
        valid_if_id_s = valid_if_id_r;
        pend_pc_s     = pend_pc_r;
        pend_instr_s  = pend_instr_r;
        pend_valid_s  = pend_valid_r;
        pc_inc_s      = pc_r + ADDR_WIDTH'(PC_STEP);

        case (state_r)
            ST_IDLE: begin
                state_s = ST_REQ;
            end
            ST_REQ, ST_WAIT: begin
                if (Branch_Taken) begin
                    pc_s          = Branch_Target;
                    instr_if_id_s = {INSTR_WIDTH{1'b0}};
                    valid_if_id_s = 1'b0;
                    pend_valid_s  = 1'b0;
                    state_s       = ST_REQ;
                end else if (Instr_Mem_Ready) begin
                    pc_s = pc_inc_s;
                    if (!Hazard_Detected) begin
                        pc_if_id_s    = pc_r;
                        instr_if_id_s = Instr_Mem_Data;
                        valid_if_id_s = 1'b1;
                        state_s       = ST_REQ;
                    end else begin
                        pend_pc_s    = pc_r;
                        pend_instr_s = Instr_Mem_Data;
                        pend_valid_s = 1'b1;
                        state_s      = ST_HOLD;
                    end
                end else begin
                    state_s = ST_WAIT;
                    if (!Hazard_Detected) begin
                        instr_if_id_s = {INSTR_WIDTH{1'b0}};
                        valid_if_id_s = 1'b0;
                    end else begin
                        valid_if_id_s = valid_if_id_r;
                    end
                end
            end
            ST_HOLD: begin
                if (Branch_Taken) begin
                    pc_s          = Branch_Target;
                    instr_if_id_s = {INSTR_WIDTH{1'b0}};
                    valid_if_id_s = 1'b0;
                    pend_valid_s  = 1'b0;
                    state_s       = ST_REQ;
                end else if (!Hazard_Detected) begin
                    pc_if_id_s    = pend_pc_r;
                    instr_if_id_s = pend_instr_r;
                    valid_if_id_s = pend_valid_r;
                    pend_valid_s  = 1'b0;
                    state_s       = ST_REQ;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, PC, IF/ID and pending-buffer registers with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Reset_N) begin
            state_r       <= ST_IDLE;
            pc_r          <= ADDR_WIDTH'(RESET_PC);
            pc_if_id_r    <= {ADDR_WIDTH{1'b0}};
            instr_if_id_r <= {INSTR_WIDTH{1'b0}};
            valid_if_id_r <= 1'b0;
            pend_pc_r     <= {ADDR_WIDTH{1'b0}};
            pend_instr_r  <= {INSTR_WIDTH{1'b0}};
            pend_valid_r  <= 1'b0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            pc_if_id_r    <= pc_if_id_s;
            instr_if_id_r <= instr_if_id_s;
            valid_if_id_r <= valid_if_id_s;
            pend_pc_r     <= pend_pc_s;
            pend_instr_r  <= pend_instr_s;
            pend_valid_r  <= pend_valid_s;
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;

    assign Stall_Cycle_Count = stall_cnt_r;
    assign Flush_Count       = flush_cnt_r;

    // Saturating counters of stalled cycles and branch flush cycles.
    always_ff @(posedge Clock) begin
        if (!Reset_N) begin
            stall_cnt_r <= 16'h0000;
            flush_cnt_r <= 16'h0000;
        end else begin
            if ((Fetch_Stall || Hazard_Detected) && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'h0001;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (Branch_Taken && (flush_cnt_r != 16'hFFFF)) begin
                flush_cnt_r <= flush_cnt_r + 16'h0001;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed testbench for instruction_fetch_stage with hand-computed expectations.
// The memory model returns {16'hC0DE, addr[15:0]} for every address.
module tb_instruction_fetch_stage;

    logic        Clock;
    logic        Reset_N;
    logic        Hazard_Detected;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic        Instr_Mem_Req;
    logic [31:0] Instr_Mem_Addr;
    logic        Instr_Mem_Ready;
    logic [31:0] Instr_Mem_Data;
    logic [31:0] PC_IF_ID;
    logic [31:0] Instruction_IF_ID;
    logic        Valid_IF_ID;
    logic        Fetch_Stall;
`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] Stall_Cycle_Count;
    logic [15:0] Flush_Count;
`endif

    int checks_cnt = 0;
    int errors_cnt = 0;

    instruction_fetch_stage dut (
        .Clock             (Clock),
        .Reset_N           (Reset_N),
        .Hazard_Detected   (Hazard_Detected),
        .Branch_Taken      (Branch_Taken),
        .Branch_Target     (Branch_Target),
        .Instr_Mem_Req     (Instr_Mem_Req),
        .Instr_Mem_Addr    (Instr_Mem_Addr),
        .Instr_Mem_Ready   (Instr_Mem_Ready),
        .Instr_Mem_Data    (Instr_Mem_Data),
        .PC_IF_ID          (PC_IF_ID),
        .Instruction_IF_ID (Instruction_IF_ID),
        .Valid_IF_ID       (Valid_IF_ID),
`ifdef FETCH_PERF_COUNT_EN
        .Stall_Cycle_Count (Stall_Cycle_Count),
        .Flush_Count       (Flush_Count),
`endif
        .Fetch_Stall       (Fetch_Stall)
    );

    assign Instr_Mem_Data = {16'hC0DE, Instr_Mem_Addr[15:0]};

    // Free-running clock.
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr, input logic v);
        check_val({tag, ".pc"}, PC_IF_ID, pc);
        check_val({tag, ".instr"}, Instruction_IF_ID, instr);
        check_val({tag, ".valid"}, {31'd0, Valid_IF_ID}, {31'd0, v});
    endtask

    task automatic check_mem(input string tag, input logic req, input logic [31:0] addr, input logic stall);
        check_val({tag, ".req"}, {31'd0, Instr_Mem_Req}, {31'd0, req});
        check_val({tag, ".addr"}, Instr_Mem_Addr, addr);
        check_val({tag, ".stall"}, {31'd0, Fetch_Stall}, {31'd0, stall});
    endtask

    // Directed stimulus sequence.
    initial begin
        Reset_N = 1'b0; Hazard_Detected = 1'b0; Branch_Taken = 1'b0;
        Branch_Target = 32'h0; Instr_Mem_Ready = 1'b1;
        tick();
        tick();
        check_mem("reset", 1'b0, 32'h0, 1'b0);
        check_ifid("reset", 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_COUNT_EN
        check_val("reset.stall_cnt", {16'd0, Stall_Cycle_Count}, 32'h0);
        check_val("reset.flush_cnt", {16'd0, Flush_Count}, 32'h0);
`endif

        // Streaming with Ready tied high.
        Reset_N = 1'b1;
        tick();
        check_mem("idle2req", 1'b1, 32'h0, 1'b0);
        check_ifid("idle2req", 32'h0, 32'h0, 1'b0);
        tick();
        check_mem("s1", 1'b1, 32'h4, 1'b0);
        check_ifid("s1", 32'h0, 32'hC0DE_0000, 1'b1);
        tick();
        check_mem("s2", 1'b1, 32'h8, 1'b0);
        check_ifid("s2", 32'h4, 32'hC0DE_0004, 1'b1);

        // Memory not ready for three cycles at PC=8.
        Instr_Mem_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_mem("wait", 1'b1, 32'h8, 1'b1);
            check_ifid("wait", 32'h4, 32'h0, 1'b0);
        end
        Instr_Mem_Ready = 1'b1;
        tick();
        check_mem("wait_done", 1'b1, 32'hC, 1'b0);
        check_ifid("wait_done", 32'h8, 32'hC0DE_0008, 1'b1);

        // Hazard for two cycles while data returns at PC=C.
        Hazard_Detected = 1'b1;
        tick();
        check_mem("hold1", 1'b0, 32'h10, 1'b1);
        check_ifid("hold1", 32'h8, 32'hC0DE_0008, 1'b1);
        tick();
        check_mem("hold2", 1'b0, 32'h10, 1'b1);
        check_ifid("hold2", 32'h8, 32'hC0DE_0008, 1'b1);
        Hazard_Detected = 1'b0;
        tick();
        check_mem("release", 1'b1, 32'h10, 1'b0);
        check_ifid("release", 32'hC, 32'hC0DE_000C, 1'b1);

        // Taken branch to 0x100 at PC=10.
        Branch_Taken = 1'b1; Branch_Target = 32'h100;
        tick();
        check_mem("br", 1'b1, 32'h100, 1'b0);
        check_val("br.valid", {31'd0, Valid_IF_ID}, 32'h0);
        check_val("br.instr", Instruction_IF_ID, 32'h0);
        Branch_Taken = 1'b0;
        tick();
        check_mem("br_next", 1'b1, 32'h104, 1'b0);
        check_ifid("br_next", 32'h100, 32'hC0DE_0100, 1'b1);

        // Branch together with hazard while HOLD is buffering 0x104.
        Hazard_Detected = 1'b1;
        tick();
        check_mem("hold_b", 1'b0, 32'h108, 1'b1);
        check_ifid("hold_b", 32'h100, 32'hC0DE_0100, 1'b1);
        Branch_Taken = 1'b1; Branch_Target = 32'h200;
        tick();
        check_mem("br_hz", 1'b1, 32'h200, 1'b0);
        check_val("br_hz.valid", {31'd0, Valid_IF_ID}, 32'h0);
        Branch_Taken = 1'b0; Hazard_Detected = 1'b0;
        tick();
        check_mem("br_hz_next", 1'b1, 32'h204, 1'b0);
        check_ifid("br_hz_next", 32'h200, 32'hC0DE_0200, 1'b1);

        // Reset asserted during WAIT.
        Instr_Mem_Ready = 1'b0;
        tick();
        check_mem("wait2", 1'b1, 32'h204, 1'b1);
        Reset_N = 1'b0;
        tick();
        check_mem("rst_wait", 1'b0, 32'h0, 1'b0);
        check_ifid("rst_wait", 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_COUNT_EN
        check_val("rst_wait.stall_cnt", {16'd0, Stall_Cycle_Count}, 32'h0);
        check_val("rst_wait.flush_cnt", {16'd0, Flush_Count}, 32'h0);
`endif

        // PC wrap-around at the top of the address space.
        Reset_N = 1'b1;
        tick();
        Branch_Taken = 1'b1; Branch_Target = 32'hFFFF_FFFC;
        tick();
        check_mem("wrap_br", 1'b1, 32'hFFFF_FFFC, 1'b0);
        Branch_Taken = 1'b0; Instr_Mem_Ready = 1'b1;
        tick();
        check_mem("wrap", 1'b1, 32'h0, 1'b0);
        check_ifid("wrap", 32'hFFFF_FFFC, 32'hC0DE_FFFC, 1'b1);

        // Hazard with no data: IF/ID held instead of bubbled.
        Hazard_Detected = 1'b1; Instr_Mem_Ready = 1'b0;
        tick();
        check_mem("hz_wait", 1'b1, 32'h0, 1'b1);
        check_ifid("hz_wait", 32'hFFFF_FFFC, 32'hC0DE_FFFC, 1'b1);
`ifdef FETCH_PERF_COUNT_EN
        check_val("perf.stall_cnt", {16'd0, Stall_Cycle_Count}, 32'h1);
        check_val("perf.flush_cnt", {16'd0, Flush_Count}, 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
